// File: rtl/trace_cmd_sequencer_pkg.sv
// Shared types for the trace command sequencer: command codes, FSM states
// and the default trace-entry layout.
package trace_cmd_sequencer_pkg;

    localparam int ADDR_BITS_DEF = 32;
    localparam int CMDSIZE_DEF   = 4;

    // Trace command codes; 7 and 10-15 are illegal and get dropped.
    typedef enum logic [3:0] {
        RD_DATA   = 4'd0,
        WR_DATA   = 4'd1,
        RD_INST   = 4'd2,
        SNP_INV   = 4'd3,
        SNP_RD    = 4'd4,
        SNP_WR    = 4'd5,
        SNP_RWITM = 4'd6,
        CLEAR     = 4'd8,
        PRINT     = 4'd9
    } trace_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CTRL  = 2'd3
    } seq_state_e;

    // Default-width layout of one buffered record, MSB first.
    typedef struct packed {
        logic [CMDSIZE_DEF-1:0]   command;
        logic [ADDR_BITS_DEF-1:0] address;
        logic                     last;
    } trace_entry_t;

endpackage

// File: rtl/trace_cmd_sequencer_if.sv
// Trace input, LLC request/response and statistics signals of the sequencer.
// slave = the sequencer itself, master = the trace source / LLC / report side.
interface trace_cmd_sequencer_if #(
    parameter int ADDR_BITS = 32,
    parameter int CMDSIZE   = 4,
    parameter int CNT_W     = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CMDSIZE-1:0]   in_command;
    logic [ADDR_BITS-1:0] in_address;
    logic                 in_last;

    logic                 llc_valid;
    logic                 llc_ready;
    logic [CMDSIZE-1:0]   llc_command;
    logic [ADDR_BITS-1:0] llc_address;
    logic                 llc_rsp_valid;
    logic                 llc_rsp_hit;
    logic                 llc_clear;

    logic                 stats_print;
    logic [CNT_W-1:0]     reads;
    logic [CNT_W-1:0]     writes;
    logic [CNT_W-1:0]     hits;
    logic [CNT_W-1:0]     misses;
    logic [CNT_W-1:0]     snoops;
    logic [CNT_W-1:0]     bad_cmds;
    logic                 done;
    logic                 busy;

    modport slave (
        input  in_valid, in_command, in_address, in_last,
        input  llc_ready, llc_rsp_valid, llc_rsp_hit,
        output in_ready, llc_valid, llc_command, llc_address, llc_clear,
        output stats_print, reads, writes, hits, misses, snoops, bad_cmds,
        output done, busy
    );

    modport master (
        output in_valid, in_command, in_address, in_last,
        output llc_ready, llc_rsp_valid, llc_rsp_hit,
        input  in_ready, llc_valid, llc_command, llc_address, llc_clear,
        input  stats_print, reads, writes, hits, misses, snoops, bad_cmds,
        input  done, busy
    );
endinterface

// File: rtl/trace_cmd_sequencer_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable; pushes when full and pops when
// empty are ignored.
module trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted pushes and pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/trace_cmd_sequencer.sv
// Trace command sequencer: buffers trace records, dispatches cache/snoop
// operations to the LLC one at a time, executes clear/print locally and
// keeps saturating statistics.
module trace_cmd_sequencer
    import trace_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int CMDSIZE   = CMDSIZE_DEF,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 32
) (
    input  logic clk,
    input  logic rst_n,
    trace_cmd_sequencer_if.slave bus
);
    localparam int ENTRY_W = CMDSIZE + ADDR_BITS + 1;

    typedef struct packed {
        logic [CMDSIZE-1:0]   command;
        logic [ADDR_BITS-1:0] address;
        logic                 last;
    } entry_t;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + CNT_W'(1);
        end
        return res;
    endfunction

    seq_state_e           r_state;
    logic [CMDSIZE-1:0]   r_cmd;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_last;
    logic                 r_llc_valid;
    logic                 r_llc_clear;
    logic                 r_stats_print;
    logic                 r_done;
    logic [CNT_W-1:0]     r_reads;
    logic [CNT_W-1:0]     r_writes;
    logic [CNT_W-1:0]     r_hits;
    logic [CNT_W-1:0]     r_misses;
    logic [CNT_W-1:0]     r_snoops;
    logic [CNT_W-1:0]     r_bad;

    entry_t               w_in_entry;
    entry_t               w_head;
    logic [ENTRY_W-1:0]   w_head_bits;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_is_op;
    logic                 w_head_is_ctrl;
    logic                 w_cmd_is_read;
    logic                 w_cmd_is_write;
    logic                 w_cmd_is_snoop;

    assign w_in_entry = '{command: bus.in_command, address: bus.in_address, last: bus.in_last};
    assign w_head     = w_head_bits;
    assign w_push     = bus.in_valid && !w_full;
    assign w_pop      = (r_state == ST_IDLE) && !w_empty;

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_in_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Classify the FIFO head: LLC operation, local control, or illegal.
    always_comb begin
        w_head_is_op   = 1'b0;
        w_head_is_ctrl = 1'b0;
        if (w_head.command <= CMDSIZE'(SNP_RWITM)) begin
            w_head_is_op = 1'b1;
        end else if ((w_head.command == CMDSIZE'(CLEAR)) ||
                     (w_head.command == CMDSIZE'(PRINT))) begin
            w_head_is_ctrl = 1'b1;
        end else begin
            w_head_is_op   = 1'b0;
            w_head_is_ctrl = 1'b0;
        end
    end

    // Decide which statistics the in-flight operation feeds.
    always_comb begin
        w_cmd_is_read  = (r_cmd == CMDSIZE'(RD_DATA)) || (r_cmd == CMDSIZE'(RD_INST));
        w_cmd_is_write = (r_cmd == CMDSIZE'(WR_DATA));
        w_cmd_is_snoop = (r_cmd >= CMDSIZE'(SNP_INV)) && (r_cmd <= CMDSIZE'(SNP_RWITM));
    end

    // Sequencer FSM: pop, dispatch, await response, run control commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd         <= CMDSIZE'(0);
            r_addr        <= ADDR_BITS'(0);
            r_last        <= 1'b0;
            r_llc_valid   <= 1'b0;
            r_llc_clear   <= 1'b0;
            r_stats_print <= 1'b0;
            r_done        <= 1'b0;
            r_reads       <= CNT_W'(0);
            r_writes      <= CNT_W'(0);
            r_hits        <= CNT_W'(0);
            r_misses      <= CNT_W'(0);
            r_snoops      <= CNT_W'(0);
            r_bad         <= CNT_W'(0);
        end else begin
            r_llc_clear   <= 1'b0;
            r_stats_print <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cmd  <= w_head.command;
                        r_addr <= w_head.address;
                        r_last <= w_head.last;
                        if (w_head_is_op) begin
                            r_llc_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else if (w_head_is_ctrl) begin
                            r_llc_clear   <= (w_head.command == CMDSIZE'(CLEAR));
                            r_stats_print <= (w_head.command == CMDSIZE'(PRINT));
                            r_state       <= ST_CTRL;
                        end else begin
                            // Illegal command: dropped here, which also completes it.
                            r_bad <= sat_inc(r_bad);
                            if (w_head.last) begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.llc_ready) begin
                        r_llc_valid <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.llc_rsp_valid) begin
                        if (w_cmd_is_read) begin
                            r_reads <= sat_inc(r_reads);
                        end
                        if (w_cmd_is_write) begin
                            r_writes <= sat_inc(r_writes);
                        end
                        if ((w_cmd_is_read || w_cmd_is_write) && bus.llc_rsp_hit) begin
                            r_hits <= sat_inc(r_hits);
                        end
                        if ((w_cmd_is_read || w_cmd_is_write) && !bus.llc_rsp_hit) begin
                            r_misses <= sat_inc(r_misses);
                        end
                        if (w_cmd_is_snoop) begin
                            r_snoops <= sat_inc(r_snoops);
                        end
                        if (r_last) begin
                            r_done <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_CTRL: begin
                    // Clear takes effect as the pulse ends so the pulse cycle sees old values.
                    if (r_cmd == CMDSIZE'(CLEAR)) begin
                        r_reads  <= CNT_W'(0);
                        r_writes <= CNT_W'(0);
                        r_hits   <= CNT_W'(0);
                        r_misses <= CNT_W'(0);
                        r_snoops <= CNT_W'(0);
                        r_bad    <= CNT_W'(0);
                    end
                    if (r_last) begin
                        r_done <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_llc_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.llc_valid   = r_llc_valid;
    assign bus.llc_command = r_cmd;
    assign bus.llc_address = r_addr;
    assign bus.llc_clear   = r_llc_clear;
    assign bus.stats_print = r_stats_print;
    assign bus.reads       = r_reads;
    assign bus.writes      = r_writes;
    assign bus.hits        = r_hits;
    assign bus.misses      = r_misses;
    assign bus.snoops      = r_snoops;
    assign bus.bad_cmds    = r_bad;
    assign bus.done        = r_done;
    assign bus.busy        = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_trace_cmd_sequencer.sv
// Directed bench for trace_cmd_sequencer (DEPTH=4, CNT_W=2).
module tb_trace_cmd_sequencer;
    import trace_cmd_sequencer_pkg::*;

    localparam int AW    = 32;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    trace_cmd_sequencer_if #(.ADDR_BITS(AW), .CMDSIZE(CW), .CNT_W(CNT_W)) bus();

    trace_cmd_sequencer #(
        .ADDR_BITS (AW),
        .CMDSIZE   (CW),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Negedge monitor: snapshot counters on each print pulse, count clears and valid cycles.
    int         n_prints   = 0;
    int         n_clears   = 0;
    int         n_valid_hi = 0;
    logic [1:0] snap_reads  [8];
    logic [1:0] snap_writes [8];
    logic [1:0] snap_hits   [8];
    logic [1:0] snap_misses [8];
    always @(negedge clk) begin
        if (bus.stats_print) begin
            if (n_prints < 8) begin
                snap_reads[n_prints]  <= bus.reads;
                snap_writes[n_prints] <= bus.writes;
                snap_hits[n_prints]   <= bus.hits;
                snap_misses[n_prints] <= bus.misses;
            end
            n_prints <= n_prints + 1;
        end
        if (bus.llc_clear) n_clears <= n_clears + 1;
        if (bus.llc_valid) n_valid_hi <= n_valid_hi + 1;
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        last;
        logic        hit;
        logic [1:0]  e_reads;
        logic [1:0]  e_writes;
        logic [1:0]  e_hits;
        logic [1:0]  e_misses;
        logic [1:0]  e_snoops;
        logic        e_done;
    } vec_t;
    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] cmd, input logic [31:0] addr, input logic last);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.in_command = cmd;
        bus.in_address = addr;
        bus.in_last    = last;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("push_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic serve(input string name, input logic [3:0] cmd, input logic [31:0] addr,
                         input logic hit);
        int n;
        n = 0;
        while (!bus.llc_valid && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, 64'(bus.llc_valid), 64'd1);
        chk({name, "_cmd"}, 64'(bus.llc_command), 64'(cmd));
        chk({name, "_addr"}, 64'(bus.llc_address), 64'(addr));
        bus.llc_ready = 1'b1;
        tick();
        bus.llc_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(bus.llc_valid), 64'd0);
        bus.llc_rsp_valid = 1'b1;
        bus.llc_rsp_hit   = hit;
        tick();
        bus.llc_rsp_valid = 1'b0;
        bus.llc_rsp_hit   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_p;
        int base_c;
        int base_v;
        logic [1:0] e_sat;

        vecs[0] = '{RD_DATA, 32'h1000, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0};
        vecs[1] = '{WR_DATA, 32'h1000, 1'b0, 1'b1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 1'b0};
        vecs[2] = '{RD_INST, 32'h2000, 1'b0, 1'b1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 1'b0};
        vecs[3] = '{SNP_RD,  32'h3000, 1'b1, 1'b0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 1'b1};

        bus.in_valid      = 1'b0;
        bus.in_command    = 4'd0;
        bus.in_address    = 32'd0;
        bus.in_last       = 1'b0;
        bus.llc_ready     = 1'b0;
        bus.llc_rsp_valid = 1'b0;
        bus.llc_rsp_hit   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_llc_valid", 64'(bus.llc_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_reads", 64'(bus.reads), 64'd0);
        chk("rst_clear", 64'(bus.llc_clear), 64'd0);
        chk("rst_print", 64'(bus.stats_print), 64'd0);
        rst_n = 1'b1;
        tick();

        // Stream and counts, one record at a time through an empty FIFO
        for (int i = 0; i < 4; i++) begin
            push(vecs[i].cmd, vecs[i].addr, vecs[i].last);
            chk("lat_n1", 64'(bus.llc_valid), 64'd0);
            tick();
            chk("lat_n2", 64'(bus.llc_valid), 64'd1);
            serve("stream", vecs[i].cmd, vecs[i].addr, vecs[i].hit);
            chk("st_reads", 64'(bus.reads), 64'(vecs[i].e_reads));
            chk("st_writes", 64'(bus.writes), 64'(vecs[i].e_writes));
            chk("st_hits", 64'(bus.hits), 64'(vecs[i].e_hits));
            chk("st_misses", 64'(bus.misses), 64'(vecs[i].e_misses));
            chk("st_snoops", 64'(bus.snoops), 64'(vecs[i].e_snoops));
            chk("st_done", 64'(bus.done), 64'(vecs[i].e_done));
        end
        chk("st_bad", 64'(bus.bad_cmds), 64'd0);
        tick();
        chk("st_busy_end", 64'(bus.busy), 64'd0);

        // Backpressure: LLC stalled, 4 in FIFO + 1 in ISSUE, 6th refused
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_command = 4'(i);
            bus.in_address = 32'h100 + 32'(i);
            bus.in_last    = 1'b0;
            chk("bp_ready", 64'(bus.in_ready), 64'd1);
            tick();
        end
        bus.in_command = 4'd5;
        bus.in_address = 32'h105;
        chk("bp_full", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_full_hold", 64'(bus.in_ready), 64'd0);
            chk("bp_valid_hold", 64'(bus.llc_valid), 64'd1);
            chk("bp_addr_hold", 64'(bus.llc_address), 64'h100);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve("bp", 4'(i), 32'h100 + 32'(i), 1'b0);
        end
        push(4'd5, 32'h105, 1'b0);
        serve("bp", 4'd5, 32'h105, 1'b0);
        tick();
        chk("bp_busy_end", 64'(bus.busy), 64'd0);

        // Control commands: 3 reads, then print, clear, print
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(RD_DATA, 32'h40 + 32'(i), 1'b0);
            serve("ctl_rd", RD_DATA, 32'h40 + 32'(i), 1'b1);
        end
        chk("ctl_reads_pre", 64'(bus.reads), 64'd3);
        base_p = n_prints;
        base_c = n_clears;
        push(PRINT, 32'd0, 1'b0);
        push(CLEAR, 32'd0, 1'b0);
        push(PRINT, 32'd0, 1'b0);
        repeat (6) tick();
        chk("ctl_print_cnt", 64'(n_prints - base_p), 64'd2);
        chk("ctl_clear_cnt", 64'(n_clears - base_c), 64'd1);
        chk("ctl_p1_reads", 64'(snap_reads[base_p]), 64'd3);
        chk("ctl_p1_hits", 64'(snap_hits[base_p]), 64'd3);
        chk("ctl_p2_reads", 64'(snap_reads[base_p + 1]), 64'd0);
        chk("ctl_p2_hits", 64'(snap_hits[base_p + 1]), 64'd0);
        chk("ctl_p2_writes", 64'(snap_writes[base_p + 1]), 64'd0);
        chk("ctl_p2_misses", 64'(snap_misses[base_p + 1]), 64'd0);
        chk("ctl_done", 64'(bus.done), 64'd0);

        // Illegal commands dropped
        do_reset();
        base_v = n_valid_hi;
        push(4'd7, 32'hFF, 1'b0);
        push(4'd11, 32'h0, 1'b1);
        repeat (4) tick();
        chk("ill_bad", 64'(bus.bad_cmds), 64'd2);
        chk("ill_done", 64'(bus.done), 64'd1);
        chk("ill_no_valid", 64'(n_valid_hi - base_v), 64'd0);
        chk("ill_busy", 64'(bus.busy), 64'd0);

        // Saturation at all-ones with CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(RD_DATA, 32'h500 + 32'(i), 1'b0);
            serve("sat", RD_DATA, 32'h500 + 32'(i), 1'b1);
            e_sat = (i >= 2) ? 2'd3 : 2'(i + 1);
            chk("sat_reads", 64'(bus.reads), 64'(e_sat));
            chk("sat_hits", 64'(bus.hits), 64'(e_sat));
        end
        chk("sat_misses", 64'(bus.misses), 64'd0);

        // Reset while waiting for a response; late response must be ignored
        do_reset();
        push(RD_DATA, 32'h10, 1'b0);
        for (int n = 0; n < 20 && !bus.llc_valid; n++) tick();
        chk("mw_valid", 64'(bus.llc_valid), 64'd1);
        bus.llc_ready = 1'b1;
        tick();
        bus.llc_ready = 1'b0;
        chk("mw_busy_wait", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("mw_rst_valid", 64'(bus.llc_valid), 64'd0);
        chk("mw_rst_busy", 64'(bus.busy), 64'd0);
        chk("mw_rst_ready", 64'(bus.in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        bus.llc_rsp_valid = 1'b1;
        bus.llc_rsp_hit   = 1'b1;
        tick();
        bus.llc_rsp_valid = 1'b0;
        bus.llc_rsp_hit   = 1'b0;
        tick();
        chk("mw_reads", 64'(bus.reads), 64'd0);
        chk("mw_hits", 64'(bus.hits), 64'd0);
        chk("mw_misses", 64'(bus.misses), 64'd0);
        chk("mw_snoops", 64'(bus.snoops), 64'd0);
        chk("mw_llc_valid", 64'(bus.llc_valid), 64'd0);
        chk("mw_busy", 64'(bus.busy), 64'd0);
        chk("mw_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mw_done", 64'(bus.done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
